// File: rtl/sa_skew_feeder_if.sv
// Bundles the pass control, the vector-pair input handshake and the skewed lane outputs of the skew feeder.
// Latency: not applicable; this is a signal bundle only.
// Backpressure: in_valid/in_ready on the vector input; lane outputs are free-running with per-lane valids.
//
// Ports (master = pass controller / vector source, slave = sa_skew_feeder):
//   start, k_len            pass request and reduction depth
//   in_valid, in_ready      a_vec/b_vec handshake
//   a_vec, b_vec            one A column-slice and one B row-slice, lane i in bits [i*DW +: DW]
//   west_row_out, west_vld  skewed row lanes toward PE(i,0)
//   north_col_out, north_vld skewed column lanes toward PE(0,j)
//   busy, done              pass status
interface sa_skew_feeder_if #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int KW = 7
);
    logic            start;
    logic [KW-1:0]   k_len;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] a_vec;
    logic [N*DW-1:0] b_vec;
    logic [N*DW-1:0] west_row_out;
    logic [N*DW-1:0] north_col_out;
    logic [N-1:0]    west_vld;
    logic [N-1:0]    north_vld;
    logic            busy;
    logic            done;

    modport master (
        output start, k_len, in_valid, a_vec, b_vec,
        input  in_ready, west_row_out, north_col_out, west_vld, north_vld, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, a_vec, b_vec,
        output in_ready, west_row_out, north_col_out, west_vld, north_vld, busy, done
    );
endinterface

// File: rtl/sa_skew_feeder.sv
// Feeds an N x N systolic PE array: triangular skew on west row lanes and north column lanes, one pass of k_len steps.
// Latency: a transfer at edge t shows on lane i after edge t+1+i; done follows K+2N edges after the first transfer.
// Backpressure: in_ready is high in STREAM until k_len pairs are taken; in_valid=0 injects a uniform zero bubble.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         sa_skew_feeder_if slave: start/k_len, in_valid/in_ready, a_vec/b_vec,
//               west_row_out/west_vld, north_col_out/north_vld, busy, done
module sa_skew_feeder #(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int K_MAX = 64,
    parameter int KW    = $clog2(K_MAX + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    sa_skew_feeder_if.slave bus
);

    // Drain of the deepest skew lane, traversal across the array and the final PE register.
    localparam int              FLUSH_LEN  = 2 * N - 1;
    localparam int              FW         = $clog2(FLUSH_LEN + 1);
    localparam logic [KW-1:0]   K_MAX_W    = KW'(K_MAX);
    localparam logic [FW-1:0]   FLUSH_LAST = FW'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [KW-1:0] k_len_q;
    logic [KW-1:0] k_cnt_q;
    logic [FW-1:0] flush_cnt_q;
    logic          done_q;
    logic [KW-1:0] k_len_clamped;
    logic          in_ready_c;
    logic          xfer;

    assign k_len_clamped = (bus.k_len > K_MAX_W) ? K_MAX_W : bus.k_len;

    // Ready comes only from state and count so the source never sees a combinational loop through in_valid.
    assign in_ready_c = (state_q == STREAM) && (k_cnt_q < k_len_q);
    assign xfer       = in_ready_c && bus.in_valid;

    // ------------------------------------------------------------------
    // Pass sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (k_len_clamped == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                // Leave one cycle after the last transfer: that cycle has in_ready low and the count complete.
                if (k_cnt_q == k_len_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_len_q     <= '0;
            k_cnt_q     <= '0;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            if ((state_q == IDLE) && bus.start) begin
                k_len_q <= k_len_clamped;
                k_cnt_q <= '0;
            end else if (xfer) begin
                k_cnt_q <= k_cnt_q + KW'(1);
            end
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + FW'(1) : '0;
            // done is registered off DONE so it rises once the last PE sum has settled.
            done_q      <= (state_q == DONE);
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.busy     = (state_q == STREAM) || (state_q == FLUSH);
    assign bus.done     = done_q;

    // ------------------------------------------------------------------
    // Skew chains: lane i has i+1 shift stages plus an output register.
    // Stage 0 loads a zero word with vld=0 whenever no transfer happens,
    // so every lane shifts every cycle and A/B stay aligned across bubbles.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] a_pipe [0:i];
        logic [DW-1:0] b_pipe [0:i];
        logic          v_pipe [0:i];
        logic [DW-1:0] a_out_q;
        logic [DW-1:0] b_out_q;
        logic          v_out_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j <= i; j++) begin
                    a_pipe[j] <= '0;
                    b_pipe[j] <= '0;
                    v_pipe[j] <= 1'b0;
                end
                a_out_q <= '0;
                b_out_q <= '0;
                v_out_q <= 1'b0;
            end else begin
                a_pipe[0] <= xfer ? bus.a_vec[i*DW +: DW] : '0;
                b_pipe[0] <= xfer ? bus.b_vec[i*DW +: DW] : '0;
                v_pipe[0] <= xfer;
                for (int j = 1; j <= i; j++) begin
                    a_pipe[j] <= a_pipe[j-1];
                    b_pipe[j] <= b_pipe[j-1];
                    v_pipe[j] <= v_pipe[j-1];
                end
                a_out_q <= a_pipe[i];
                b_out_q <= b_pipe[i];
                v_out_q <= v_pipe[i];
            end
        end

        assign bus.west_row_out[i*DW +: DW]  = a_out_q;
        assign bus.north_col_out[i*DW +: DW] = b_out_q;
        assign bus.west_vld[i]               = v_out_q;
        assign bus.north_vld[i]              = v_out_q;
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder: lane scoreboard plus per-scenario tasks.
// Latency: not applicable.
// Backpressure: the bench drives in_valid and stalls explicitly where a scenario needs bubbles.
module tb_sa_skew_feeder;
    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int K_MAX = 64;
    localparam int KW    = $clog2(K_MAX + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_skew_feeder_if #(.N(N), .DW(DW), .KW(KW)) bus ();

    sa_skew_feeder #(.N(N), .DW(DW), .K_MAX(K_MAX), .KW(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // number of rising edges seen so far

    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    exp_t wq [N][$];
    exp_t nq [N][$];
    int   xfer_log [$];   // edge numbers of accepted transfers

    // ------------------------------------------------------------------
    // Lane scoreboard: handshakes push expected lane words with the cycle
    // they are due; every cycle each lane must show either the due word
    // with vld=1 or zero with vld=0.
    // ------------------------------------------------------------------
    always @(negedge clk) begin : mon
        logic [DW-1:0] wd, nd;
        logic          wv, nv;
        exp_t          e;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                wq[i].delete();
                nq[i].delete();
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                wd = bus.west_row_out[i*DW +: DW];
                nd = bus.north_col_out[i*DW +: DW];
                wv = bus.west_vld[i];
                nv = bus.north_vld[i];
                checks++;
                if (wq[i].size() > 0 && wq[i][0].due == cyc) begin
                    e = wq[i].pop_front();
                    if (wv !== 1'b1 || wd !== e.d) begin
                        errors++;
                        $display("FAIL west_lane%0d cycle %0d: got vld=%0b dat=%0h, want vld=1 dat=%0h", i, cyc, wv, wd, e.d);
                    end
                end else if (wv !== 1'b0 || wd !== '0) begin
                    errors++;
                    $display("FAIL west_lane%0d_idle cycle %0d: got vld=%0b dat=%0h, want vld=0 dat=0", i, cyc, wv, wd);
                end
                checks++;
                if (nq[i].size() > 0 && nq[i][0].due == cyc) begin
                    e = nq[i].pop_front();
                    if (nv !== 1'b1 || nd !== e.d) begin
                        errors++;
                        $display("FAIL north_lane%0d cycle %0d: got vld=%0b dat=%0h, want vld=1 dat=%0h", i, cyc, nv, nd, e.d);
                    end
                end else if (nv !== 1'b0 || nd !== '0) begin
                    errors++;
                    $display("FAIL north_lane%0d_idle cycle %0d: got vld=%0b dat=%0h, want vld=0 dat=0", i, cyc, nv, nd);
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                xfer_log.push_back(cyc + 1);
                for (int i = 0; i < N; i++) begin
                    e.due = cyc + 2 + i;
                    e.d   = bus.a_vec[i*DW +: DW];
                    wq[i].push_back(e);
                    e.d   = bus.b_vec[i*DW +: DW];
                    nq[i].push_back(e);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference 4x4 output-stationary PE array fed by the lanes.
    // ------------------------------------------------------------------
    int pr  [N][N];
    int pc  [N][N];
    int acc [N][N];
    bit pe_clr = 1'b0;

    always @(posedge clk) begin : pe_model
        int wi, ni;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) wi = int'($signed(bus.west_row_out[i*DW +: DW]));
                else        wi = pr[i][j-1];
                if (i == 0) ni = int'($signed(bus.north_col_out[j*DW +: DW]));
                else        ni = pc[i-1][j];
                pr[i][j]  <= wi;
                pc[i][j]  <= ni;
                acc[i][j] <= pe_clr ? 0 : acc[i][j] + wi * ni;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no comparisons inside)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input int k);
        tick();
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        tick();
        bus.start = 1'b0;
        bus.k_len = '0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    function automatic int first_xfer();
        return (xfer_log.size() > 0) ? xfer_log[0] : -1000;
    endfunction

    function automatic int last_xfer();
        return (xfer_log.size() > 0) ? xfer_log[xfer_log.size()-1] : -1000;
    endfunction

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        int seen;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.busy, bus.done, bus.west_vld, bus.north_vld} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%0b busy=%0b done=%0b wv=%0h nv=%0h, want all 0",
                     bus.in_ready, bus.busy, bus.done, bus.west_vld, bus.north_vld);
        end
        checks++;
        if (bus.west_row_out !== '0 || bus.north_col_out !== '0) begin
            errors++;
            $display("FAIL reset_data: got west=%0h north=%0h, want 0", bus.west_row_out, bus.north_col_out);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Mid-pass reset after three transfers.
        start_pass(8);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.a_vec    = {$urandom, $urandom};
            bus.b_vec    = {$urandom, $urandom};
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midpass_busy: got %0b, want 1", bus.busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.busy, bus.done, bus.west_vld, bus.north_vld} !== '0) begin
            errors++;
            $display("FAIL midpass_reset_ctrl: got rdy=%0b busy=%0b done=%0b wv=%0h nv=%0h, want all 0",
                     bus.in_ready, bus.busy, bus.done, bus.west_vld, bus.north_vld);
        end
        checks++;
        if (bus.west_row_out !== '0 || bus.north_col_out !== '0) begin
            errors++;
            $display("FAIL midpass_reset_data: got west=%0h north=%0h, want 0", bus.west_row_out, bus.north_col_out);
        end
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midpass_no_done: got %0d cycles with done/busy, want 0", seen);
        end
    endtask

    task automatic test_single();
        int at;
        xfer_log.delete();
        start_pass(1);
        bus.in_valid = 1'b1;
        bus.a_vec    = {16'd4, 16'd3, 16'd2, 16'd1};
        bus.b_vec    = {16'd8, 16'd7, 16'd6, 16'd5};
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready_drop: got %0b, want 0", bus.in_ready);
        end
        wait_done(60, at);
        checks++;
        if (at != first_xfer() + 1 + 2*N) begin
            errors++;
            $display("FAIL single_done_time: got cycle %0d, want %0d", at, first_xfer() + 1 + 2*N);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse: got %0b one cycle later, want 0", bus.done);
        end
        checks++;
        if (wq[N-1].size() != 0 || nq[N-1].size() != 0) begin
            errors++;
            $display("FAIL single_drain: got %0d/%0d pending, want 0", wq[N-1].size(), nq[N-1].size());
        end
    endtask

    task automatic test_back_to_back();
        int at;
        xfer_log.delete();
        start_pass(4);
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.a_vec    = {N{DW'(k)}};
            bus.b_vec    = {N{DW'(k)}};
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_after_last: got rdy=%0b busy=%0b, want rdy=0 busy=1", bus.in_ready, bus.busy);
        end
        wait_done(80, at);
        checks++;
        if (at != first_xfer() + 4 + 2*N) begin
            errors++;
            $display("FAIL b2b_done_time: got cycle %0d, want %0d", at, first_xfer() + 4 + 2*N);
        end
        checks++;
        if (xfer_log.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d transfers, want 4", xfer_log.size());
        end
    endtask

    task automatic test_stall();
        int at;
        xfer_log.delete();
        start_pass(3);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.a_vec    = {$urandom, $urandom};
            bus.b_vec    = {$urandom, $urandom};
            tick();
            if (k == 0) begin
                bus.in_valid = 1'b0;
                tick();
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_ready_hold: got %0b, want 1", bus.in_ready);
                end
                tick();
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (xfer_log.size() != 3 || xfer_log[1] - xfer_log[0] != 3) begin
            errors++;
            $display("FAIL stall_spacing: got %0d transfers, gap %0d, want 3 transfers gap 3",
                     xfer_log.size(), (xfer_log.size() > 1) ? xfer_log[1] - xfer_log[0] : -1);
        end
        wait_done(80, at);
        checks++;
        if (at != last_xfer() + 1 + 2*N) begin
            errors++;
            $display("FAIL stall_done_time: got cycle %0d, want %0d", at, last_xfer() + 1 + 2*N);
        end
    endtask

    task automatic test_k_zero();
        int s, at;
        xfer_log.delete();
        tick();
        bus.start = 1'b1;
        bus.k_len = '0;
        tick();
        s = cyc;
        bus.start = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL kzero_state: got rdy=%0b busy=%0b, want 0 0", bus.in_ready, bus.busy);
        end
        wait_done(10, at);
        checks++;
        if (at != s + 1) begin
            errors++;
            $display("FAIL kzero_done_time: got cycle %0d, want %0d", at, s + 1);
        end
        checks++;
        if (xfer_log.size() != 0) begin
            errors++;
            $display("FAIL kzero_xfers: got %0d, want 0", xfer_log.size());
        end
    endtask

    task automatic test_kmax_clamp();
        int at;
        xfer_log.delete();
        tick();
        bus.start = 1'b1;
        bus.k_len = KW'(K_MAX + 5);
        tick();
        // start stays high throughout streaming and must not restart the pass.
        for (int n = 0; n < 200; n++) begin
            bus.in_valid = 1'b1;
            bus.a_vec    = {$urandom, $urandom};
            bus.b_vec    = {$urandom, $urandom};
            tick();
            if (bus.in_ready !== 1'b1) break;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        checks++;
        if (xfer_log.size() != K_MAX) begin
            errors++;
            $display("FAIL kmax_count: got %0d transfers, want %0d", xfer_log.size(), K_MAX);
        end
        wait_done(120, at);
        checks++;
        if (at != first_xfer() + K_MAX + 2*N) begin
            errors++;
            $display("FAIL kmax_done_time: got cycle %0d, want %0d", at, first_xfer() + K_MAX + 2*N);
        end
    endtask

    task automatic test_identity_pe();
        int at;
        int bm [N][N];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                bm[i][j] = int'($urandom_range(0, 255)) - 128;
        pe_clr = 1'b1;
        tick();
        pe_clr = 1'b0;
        start_pass(N);
        for (int k = 0; k < N; k++) begin
            bus.in_valid = 1'b1;
            for (int i = 0; i < N; i++) begin
                bus.a_vec[i*DW +: DW] = (i == k) ? DW'(1) : DW'(0);
                bus.b_vec[i*DW +: DW] = DW'(bm[k][i]);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        wait_done(80, at);
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL identity_done: no done within budget");
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                checks++;
                if (acc[i][j] != bm[i][j]) begin
                    errors++;
                    $display("FAIL identity_acc[%0d][%0d]: got %0d, want %0d", i, j, acc[i][j], bm[i][j]);
                end
            end
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.k_len    = '0;
        bus.in_valid = 1'b0;
        bus.a_vec    = '0;
        bus.b_vec    = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_k_zero();
        test_kmax_clamp();
        test_identity_pe();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
- Transmit-side companion of the systolic PE array: drives west row lanes and north column lanes of an N x N PE grid.
- Accepts one A column-slice (A[:,k]) and one B row-slice (B[k,:]) per handshake.
- Applies triangular skew so lane i is delayed i cycles. A[i,k] and B[k,j] then meet at PE(i,j).
- Sequences one matrix-multiply pass of k_len steps, flushes, then pulses done.

Parameters:
- N, 4, array dimension (lanes per edge); N >= 2.
- DW, 16, lane data width; matches PE row/col width.
- K_MAX, 64, maximum reduction depth per pass.
- KW, $clog2(K_MAX+1), width of k_len.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin pass; sampled only in IDLE.
- k_len  input  KW  number of k steps; sampled with start; values above K_MAX are clamped to K_MAX.
- in_valid  input  1  a_vec/b_vec valid.
- in_ready  output  1  feeder accepts a vector pair this cycle.
- a_vec  input  N*DW  A[0..N-1,k]; lane i in bits [i*DW +: DW].
- b_vec  input  N*DW  B[k,0..N-1]; lane j in bits [j*DW +: DW].
- west_row_out  output  N*DW  to PE(i,0) west_row_in, lane i.
- north_col_out  output  N*DW  to PE(0,j) north_col_in, lane j.
- west_vld  output  N  per-lane row data valid.
- north_vld  output  N  per-lane column data valid.
- busy  output  1  high in STREAM or FLUSH.
- done  output  1  one-cycle pulse at end of pass.

Behaviour:
- Reset: all outputs 0 (data, vld, in_ready, busy, done); FSM to IDLE; k counter, flush counter and all skew registers cleared.
- FSM states: IDLE, STREAM, FLUSH, DONE.
- IDLE:
  - in_ready=0; lanes drive 0.
  - start=1 with k_len>0 -> STREAM, latch k_len.
  - start=1 with k_len==0 -> DONE directly.
- STREAM:
  - in_ready=1 while accepted count < latched k_len.
  - Transfer when in_valid & in_ready.
  - After the k_len-th transfer -> FLUSH; in_ready drops the cycle after that transfer.
- FLUSH: lasts exactly 2N-1 cycles (N-1 skew drain + N-1 array traversal + 1 PE register), then -> DONE.
- DONE: done=1 for one cycle -> IDLE. busy=0 in IDLE and DONE.
- start outside IDLE is ignored.
- Skew pipeline:
  - Lane i has an (i+1)-stage register chain. A transfer at clock edge t appears on west lane i / north lane i after edge t+1+i.
  - The matching vld bit is 1 in that same cycle.
- Bubbles:
  - A cycle in STREAM with in_valid=0 injects a zero word with vld=0 into stage 0 of every lane.
  - This shifts all lanes uniformly, so A/B alignment is preserved and the PE adds 0. Stalls are legal at any point.
- Outputs are registered; no combinational path from a_vec/b_vec to lanes.
- in_ready depends only on state and counter, never on in_valid.
- Skew chains keep shifting (zeros in) during FLUSH, DONE and IDLE. They are empty again within N cycles of the last transfer.
- Async reset mid-pass discards all in-flight data immediately; no done is issued.
- Timing reference: with k_len=K and no stalls, done is asserted K+2N cycles after the first transfer edge.

Test Plan:
- Reset during STREAM after 3 transfers -> all lanes/vld/busy/in_ready 0 immediately; FSM returns to IDLE and no done pulse follows.
- N=4, k_len=1, a_vec lanes {1,2,3,4}, b_vec {5,6,7,8}, one transfer at edge t:
  - west lane i = i+1 and north lane i = i+5, each valid in cycle t+1+i only.
  - done occurs 1+8 = 9 cycles after t.
- k_len=4, back-to-back transfers with lane values = k:
  - lane 2 shows 0,1,2,3 on consecutive cycles starting t+3.
  - in_ready falls the cycle after the 4th transfer; done occurs 12 cycles after the first transfer.
- k_len=3 with in_valid=0 for 2 cycles between transfers 1 and 2 -> every lane shows the same 2-cycle vld=0 gap, offset by its lane index.
- start with k_len=0 -> done pulses the next cycle; no vld ever set. start held high during STREAM is ignored; k_len=K_MAX+5 runs exactly K_MAX transfers.
- Full 4x4 integration with PE array, A=identity, B = random INT8 values -> accumulated sums equal B.
